// File: rtl/compute_feeder_pkg.sv
// Shared widths for the feeder datapath and the leaf-elimination weight helper.
// Each finished job contributes 2^count to the running sum.
package compute_feeder_pkg;
  localparam int BOT_W   = 128;
  localparam int COUNT_W = 6;
  localparam int SUM_W   = 64;

  function automatic logic [SUM_W-1:0] leaf_weight(input logic [COUNT_W-1:0] count);
    return {{(SUM_W-1){1'b0}}, 1'b1} << count;
  endfunction
endpackage

// File: rtl/compute_feeder_bot_fifo.sv
// Synchronous bot buffer: registered read port (data one cycle after pop), full/empty flags.
// Push is ignored when full, pop is ignored when empty; pop_dat reads zero when no pop happened.
module compute_feeder_bot_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic [DEPTH_LOG2:0]   ptr_one;

  assign ptr_one = {{DEPTH_LOG2{1'b0}}, 1'b1};
  assign empty   = wr_ptr == rd_ptr;
  // Extra pointer bit separates the full wrap from the empty case.
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pop_vld <= 1'b0;
      pop_dat <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_one;
      if (do_pop)  rd_ptr <= rd_ptr + ptr_one;
      pop_vld <= do_pop;
      pop_dat <= do_pop ? mem[rd_ptr[DEPTH_LOG2-1:0]] : '0;
    end
  end
endmodule

// File: rtl/compute_feeder.sv
// Buffers tagged bots and hands one to the core REQUEST_LATENCY cycles after each request;
// writes stall on a full buffer, requests on an empty buffer are dropped; tracks pending jobs and 2^count sum.
module compute_feeder
  import compute_feeder_pkg::*;
#(
  parameter int EXTRA_DATA_WIDTH = 14,
  parameter int REQUEST_LATENCY  = 3,
  parameter int FIFO_DEPTH_LOG2  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BOT_W-1:0]            writeBot,
  input  logic                        writeValid,
  output logic                        writeReady,
  input  logic                        requestGraph,
  output logic [BOT_W-1:0]            botOut,
  output logic                        startOut,
  output logic [EXTRA_DATA_WIDTH-1:0] extraDataOut,
  input  logic                        resultDone,
  input  logic [COUNT_W-1:0]          resultCount,
  input  logic [EXTRA_DATA_WIDTH-1:0] resultExtraData,
  output logic [SUM_W-1:0]            sumOut,
  output logic [FIFO_DEPTH_LOG2+7:0]  pendingCount,
  output logic                        idle
);
  localparam int EW = BOT_W + EXTRA_DATA_WIDTH;
  localparam int PW = 1 + EW;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        head_vld;
  logic [EW-1:0]               head_dat;
  logic [PW-1:0]               head;
  logic [PW-1:0]               tail;
  logic                        in_flight;
  logic [EXTRA_DATA_WIDTH-1:0] seq;
  logic [EXTRA_DATA_WIDTH-1:0] seq_one;
  logic [FIFO_DEPTH_LOG2+7:0]  pend_one;
  logic                        unused_tag;

  assign seq_one    = {{(EXTRA_DATA_WIDTH-1){1'b0}}, 1'b1};
  assign pend_one   = {{(FIFO_DEPTH_LOG2+7){1'b0}}, 1'b1};
  assign writeReady = !fifo_full;
  assign unused_tag = ^resultExtraData;

  compute_feeder_bot_fifo #(
    .W          (EW),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) bot_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (writeValid && writeReady),
    .push_dat ({writeBot, seq}),
    .pop      (requestGraph),
    .pop_vld  (head_vld),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) seq <= '0;
    else if (writeValid && writeReady) seq <= seq + seq_one;
  end

  assign head = {head_vld, head_dat};

  // The buffer read accounts for one cycle; the shift register covers the rest.
  if (REQUEST_LATENCY == 1) begin : g_direct
    assign tail      = head;
    assign in_flight = head_vld;
  end else begin : g_shift_register
    logic [PW-1:0] sr [REQUEST_LATENCY-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < REQUEST_LATENCY-1; i++) sr[i] <= '0;
      end else begin
        sr[0] <= head;
        for (int i = 1; i < REQUEST_LATENCY-1; i++) sr[i] <= sr[i-1];
      end
    end

    always_comb begin
      in_flight = head_vld;
      for (int i = 0; i < REQUEST_LATENCY-1; i++) in_flight = in_flight | sr[i][PW-1];
    end

    assign tail = sr[REQUEST_LATENCY-2];
  end

  assign {startOut, botOut, extraDataOut} = tail;

  always_ff @(posedge clk) begin
    if (rst) pendingCount <= '0;
    else if (startOut && !resultDone) pendingCount <= pendingCount + pend_one;
    else if (resultDone && !startOut && pendingCount != '0) pendingCount <= pendingCount - pend_one;
  end

  always_ff @(posedge clk) begin
    if (rst) sumOut <= '0;
    else if (resultDone) sumOut <= sumOut + leaf_weight(resultCount);
  end

  always_ff @(posedge clk) begin
    if (rst) idle <= 1'b1;
    else idle <= fifo_empty && !in_flight && (pendingCount == '0);
  end
endmodule

// File: tb/tb_compute_feeder.sv
// Randomized and directed stimulus against a queue/schedule reference model of the feeder.
module tb_compute_feeder;
  localparam int EDW   = 14;
  localparam int LAT   = 3;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int PCW   = DL2 + 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [127:0]     writeBot;
  logic             writeValid;
  logic             writeReady;
  logic             requestGraph;
  logic [127:0]     botOut;
  logic             startOut;
  logic [EDW-1:0]   extraDataOut;
  logic             resultDone;
  logic [5:0]       resultCount;
  logic [EDW-1:0]   resultExtraData;
  logic [63:0]      sumOut;
  logic [PCW-1:0]   pendingCount;
  logic             idle;

  compute_feeder #(
    .EXTRA_DATA_WIDTH (EDW),
    .REQUEST_LATENCY  (LAT),
    .FIFO_DEPTH_LOG2  (DL2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .writeBot        (writeBot),
    .writeValid      (writeValid),
    .writeReady      (writeReady),
    .requestGraph    (requestGraph),
    .botOut          (botOut),
    .startOut        (startOut),
    .extraDataOut    (extraDataOut),
    .resultDone      (resultDone),
    .resultCount     (resultCount),
    .resultExtraData (resultExtraData),
    .sumOut          (sumOut),
    .pendingCount    (pendingCount),
    .idle            (idle)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: buffered entries in order, and deliveries keyed by the cycle they appear.
  logic [141:0] q[$];
  logic [141:0] deliv[int];
  int           cyc    = 0;
  int           seq    = 0;
  int           pend   = 0;
  logic [63:0]  sum    = '0;
  bit           idle_m = 1'b1;

  task automatic cycle();
    bit           busy;
    bit           wr_ok;
    bit           es;
    logic [141:0] e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      deliv.delete();
      seq = 0; pend = 0; sum = '0; idle_m = 1'b1;
    end else begin
      busy = 1'b0;
      foreach (deliv[k]) if (k >= cyc) busy = 1'b1;
      idle_m = (q.size() == 0) && !busy && (pend == 0);
      es = deliv.exists(cyc);
      if (es && !resultDone) pend++;
      else if (resultDone && !es && pend > 0) pend--;
      if (resultDone) sum += 64'd1 << resultCount;
      wr_ok = q.size() < DEPTH;
      if (requestGraph && q.size() > 0) deliv[cyc + LAT] = q.pop_front();
      if (writeValid && wr_ok) begin
        q.push_back({writeBot, 14'(seq)});
        seq = (seq + 1) % (1 << EDW);
      end
      if (es) deliv.delete(cyc);
    end
    cyc++;
    @(negedge clk);
    es = deliv.exists(cyc);
    e  = es ? deliv[cyc] : '0;
    check_eq("startOut",     startOut,     es);
    check_eq("botOut",       botOut,       e[141:14]);
    check_eq("extraDataOut", extraDataOut, e[13:0]);
    check_eq("writeReady",   writeReady,   q.size() < DEPTH);
    check_eq("pendingCount", pendingCount, pend);
    check_eq("sumOut",       sumOut,       sum);
    check_eq("idle",         idle,         idle_m);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  logic [127:0] bot_a, bot_b, bot_c;

  initial begin
    rst = 1'b1; writeValid = 1'b0; writeBot = '0; requestGraph = 1'b0;
    resultDone = 1'b0; resultCount = '0; resultExtraData = '0;
    bot_a = 128'hA0A0_0000_1111_2222_3333_4444_5555_AAAA;
    bot_b = 128'hB0B0_6666_7777_8888_9999_AAAA_BBBB_BBBB;
    bot_c = 128'hC0C0_CCCC_DDDD_EEEE_FFFF_0123_4567_CCCC;
    do_reset();
    check_eq("rst_writeReady", writeReady, 1);
    check_eq("rst_idle", idle, 1);
    check_eq("rst_sum", sumOut, 0);

    // Three bots, then three back-to-back requests.
    writeValid = 1'b1;
    writeBot = bot_a; cycle();
    writeBot = bot_b; cycle();
    writeBot = bot_c; cycle();
    writeValid = 1'b0;
    cycle();
    check_eq("abc_idle_busy", idle, 0);
    requestGraph = 1'b1;
    cycle(); cycle(); cycle();
    requestGraph = 1'b0;
    check_eq("abc_bot_a", botOut, bot_a);
    check_eq("abc_tag_0", extraDataOut, 0);
    cycle();
    check_eq("abc_bot_b", botOut, bot_b);
    check_eq("abc_tag_1", extraDataOut, 1);
    cycle();
    check_eq("abc_bot_c", botOut, bot_c);
    check_eq("abc_tag_2", extraDataOut, 2);
    cycle(); cycle();
    check_eq("abc_pending", pendingCount, 3);

    // Bring pending to 2, then a start and a completion in the same cycle.
    resultDone = 1'b1; cycle(); resultDone = 1'b0;
    writeValid = 1'b1; writeBot = 128'hD; cycle(); writeValid = 1'b0;
    requestGraph = 1'b1; cycle(); requestGraph = 1'b0;
    cycle(); cycle();
    check_eq("same_cycle_start", startOut, 1);
    resultDone = 1'b1; cycle(); resultDone = 1'b0;
    check_eq("same_cycle_pending", pendingCount, 2);

    // Sum accumulation and wrap; completions with nothing pending.
    do_reset();
    resultDone = 1'b1;
    resultCount = 6'd0;  cycle(); check_eq("sum_c0", sumOut, 64'd1);
    resultCount = 6'd5;  cycle(); check_eq("sum_c5", sumOut, 64'd33);
    resultCount = 6'd63; cycle(); check_eq("sum_c63", sumOut, 64'h8000_0000_0000_0021);
    cycle();             check_eq("sum_wrap", sumOut, 64'd33);
    resultDone = 1'b0;
    check_eq("sum_pend_sat", pendingCount, 0);

    // Request against an empty buffer is dropped.
    requestGraph = 1'b1; cycle(); requestGraph = 1'b0;
    cycle(); cycle();
    check_eq("empty_req_start", startOut, 0);
    check_eq("empty_req_bot", botOut, 0);
    check_eq("empty_req_pend", pendingCount, 0);

    // Fill the buffer, overflow attempt, then one request frees a slot.
    writeValid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      writeBot = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    check_eq("full_ready", writeReady, 0);
    writeBot = 128'hDEAD; cycle();
    writeValid = 1'b0;
    requestGraph = 1'b1; cycle(); requestGraph = 1'b0;
    check_eq("full_reenable", writeReady, 1);
    cycle(); cycle(); cycle();

    // Reset one cycle after a request with bots buffered.
    requestGraph = 1'b1; cycle(); requestGraph = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;
    check_eq("midrst_ready", writeReady, 1);
    check_eq("midrst_pend", pendingCount, 0);
    check_eq("midrst_sum", sumOut, 0);
    check_eq("midrst_idle", idle, 1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("midrst_nostart", startOut, 0);
    end

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      rst             = ($urandom_range(0, 199) == 0);
      writeValid      = $urandom_range(0, 1) == 1;
      writeBot        = {$urandom, $urandom, $urandom, $urandom};
      requestGraph    = $urandom_range(0, 2) == 0;
      resultDone      = $urandom_range(0, 3) == 0;
      resultCount     = 6'($urandom_range(0, 63));
      resultExtraData = 14'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
